mc_control_unit: RTL and testbench

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

---
 rtl/mc_control_unit.sv | 143 ++++++++++++++
 tb/tb_mc_control_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
// Multicycle processor control unit: state register, halt latch,
// retired-instruction counter and the per-state control decode.
module mc_control_unit (
  input  logic        clk,
  input  logic        Reset,
  input  logic [2:0]  next_state,
  input  logic [5:0]  opcode,
  input  logic        zero,
  output logic [2:0]  state,
  output logic        ir_wr,
  output logic        pc_wr,
  output logic [1:0]  pc_src,
  output logic        reg_wr,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wb_sel,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        halted,
  output logic [15:0] instr_count
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_CEXE = 3'b010,
    S_MEM  = 3'b011,
    S_CWB  = 3'b100,
    S_BEXE = 3'b101,
    S_AEXE = 3'b110,
    S_AWB  = 3'b111
  } state_e;

  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_BNE  = 6'b110101;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  state_e      state_q, state_d;
  logic        halted_q;
  logic [15:0] cnt_q;
  logic        halt_retire;

  assign state       = state_q;
  assign halted      = halted_q;
  assign instr_count = cnt_q;

  // A halt seen in ID retires at this edge and freezes the machine in ID.
  assign halt_retire = !halted_q && (state_q == S_ID) && (opcode == OP_HALT);

  // Next state: follow the upstream next-state logic unless stopped.
  always_comb begin
    state_d = state_e'(next_state);
    if (halted_q || halt_retire) state_d = state_q;
  end

  // State, halt flag and retired-instruction counter; reset dominates.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q  <= S_IF;
      halted_q <= 1'b0;
      cnt_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      if (halt_retire) halted_q <= 1'b1;
      if (pc_wr || halt_retire) cnt_q <= cnt_q + 16'd1;
    end
  end

  // Control decode from current state, opcode and zero; silent when halted.
  always_comb begin
    ir_wr   = 1'b0;
    pc_wr   = 1'b0;
    pc_src  = 2'b00;
    reg_wr  = 1'b0;
    reg_dst = 2'b00;
    wb_sel  = 2'b00;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    if (!halted_q) begin
      case (state_q)
        S_IF: ir_wr = 1'b1;
        S_ID: begin
          if (opcode[5:3] == 3'b111) begin
            case (opcode)
              OP_J: begin
                pc_wr  = 1'b1;
                pc_src = 2'b10;
              end
              OP_JR: begin
                pc_wr  = 1'b1;
                pc_src = 2'b11;
              end
              OP_JAL: begin
                pc_wr   = 1'b1;
                pc_src  = 2'b10;
                reg_wr  = 1'b1;
                reg_dst = 2'b10;
                wb_sel  = 2'b10;
              end
              OP_HALT: pc_wr = 1'b0;
              // unassigned 111xxx opcodes retire as NOPs
              default: begin
                pc_wr  = 1'b1;
                pc_src = 2'b00;
              end
            endcase
          end
        end
        S_BEXE: begin
          pc_wr = 1'b1;
          if (((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero))
            pc_src = 2'b01;
        end
        S_AWB: begin
          reg_wr  = 1'b1;
          wb_sel  = 2'b00;
          pc_wr   = 1'b1;
          // R-type (000xxx) writes rd, immediate forms write rt
          reg_dst = (opcode[5:3] == 3'b000) ? 2'b01 : 2'b00;
        end
        S_MEM: begin
          if (opcode == OP_LW) mem_rd = 1'b1;
          if (opcode == OP_SW) begin
            mem_wr = 1'b1;
            pc_wr  = 1'b1;
          end
        end
        S_CWB: begin
          reg_wr  = 1'b1;
          reg_dst = 2'b00;
          wb_sel  = 2'b01;
          pc_wr   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: walks instruction classes through
// their state sequences and checks decoded controls and the counter.
module tb_mc_control_unit;

  logic        clk = 1'b0;
  logic        Reset;
  logic [2:0]  next_state;
  logic [5:0]  opcode;
  logic        zero;
  logic [2:0]  state;
  logic        ir_wr, pc_wr, reg_wr, mem_rd, mem_wr, halted;
  logic [1:0]  pc_src, reg_dst, wb_sel;
  logic [15:0] instr_count;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] IF = 3'b000, ID = 3'b001, CEXE = 3'b010, MEM = 3'b011,
                         CWB = 3'b100, BEXE = 3'b101, AEXE = 3'b110, AWB = 3'b111;

  mc_control_unit dut (
    .clk(clk), .Reset(Reset), .next_state(next_state), .opcode(opcode),
    .zero(zero), .state(state), .ir_wr(ir_wr), .pc_wr(pc_wr),
    .pc_src(pc_src), .reg_wr(reg_wr), .reg_dst(reg_dst), .wb_sel(wb_sel),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .halted(halted),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // packed control word: ir_wr pc_wr pc_src reg_wr reg_dst wb_sel mem_rd mem_wr
  logic [10:0] ctl;
  assign ctl = {ir_wr, pc_wr, pc_src, reg_wr, reg_dst, wb_sel, mem_rd, mem_wr};

  function automatic logic [10:0] cw(input logic iw, input logic pw, input logic [1:0] ps,
                                     input logic rw, input logic [1:0] rd, input logic [1:0] ws,
                                     input logic mr, input logic mw);
    return {iw, pw, ps, rw, rd, ws, mr, mw};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock edge; inputs change and are sampled away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1; next_state = IF; opcode = 6'd0; zero = 1'b0;
    tick();
    Reset = 1'b0;
    #1;
    check("rst_state", state, IF);
    check("rst_ctl", ctl, cw(1,0,0,0,0,0,0,0));
    check("rst_halted", halted, 0);
    check("rst_cnt", instr_count, 0);

    // ALU R-type 000000: IF->ID->aEXE->aWB
    opcode = 6'b000000; next_state = ID; #1;
    check("alu_if", ctl, cw(1,0,0,0,0,0,0,0));
    tick(); next_state = AEXE; #1;
    check("alu_id", ctl, cw(0,0,0,0,0,0,0,0));
    tick(); next_state = AWB; #1;
    check("alu_aexe", ctl, cw(0,0,0,0,0,0,0,0));
    tick(); next_state = IF; #1;
    check("alu_awb_state", state, AWB);
    check("alu_awb", ctl, cw(0,1,0,1,2'b01,0,0,0));
    tick();
    check("alu_cnt", instr_count, 1);

    // lw: IF->ID->cEXE->MEM->cWB
    opcode = 6'b110001; next_state = ID; tick();
    next_state = CEXE; tick();
    next_state = MEM; #1;
    check("lw_cexe", ctl, cw(0,0,0,0,0,0,0,0));
    tick(); next_state = CWB; #1;
    check("lw_mem", ctl, cw(0,0,0,0,0,0,1,0));
    tick(); next_state = IF; #1;
    check("lw_cwb", ctl, cw(0,1,0,1,0,2'b01,0,0));
    tick();

    // sw: IF->ID->cEXE->MEM
    opcode = 6'b110000; next_state = ID; tick();
    check("lw_cnt", instr_count, 2);
    next_state = CEXE; tick();
    next_state = MEM; tick();
    next_state = IF; #1;
    check("sw_mem", ctl, cw(0,1,0,0,0,0,0,1));
    tick();
    check("sw_cnt", instr_count, 3);

    // beq zero=1 taken
    opcode = 6'b110100; zero = 1'b1; next_state = ID; tick();
    next_state = BEXE; tick();
    next_state = IF; #1;
    check("beq_z1", ctl, cw(0,1,2'b01,0,0,0,0,0));
    zero = 1'b0; #1;
    check("beq_z0", ctl, cw(0,1,2'b00,0,0,0,0,0));
    tick();

    // bne zero=1 not taken, zero=0 taken
    opcode = 6'b110101; zero = 1'b1; next_state = ID; tick();
    next_state = BEXE; tick();
    next_state = IF; #1;
    check("bne_z1", ctl, cw(0,1,2'b00,0,0,0,0,0));
    zero = 1'b0; #1;
    check("bne_z0", ctl, cw(0,1,2'b01,0,0,0,0,0));
    tick();
    check("br_cnt", instr_count, 5);

    // ALU immediate 001000 writes rt
    opcode = 6'b001000; next_state = ID; tick();
    next_state = AEXE; tick();
    next_state = AWB; tick();
    next_state = IF; #1;
    check("alui_awb", ctl, cw(0,1,0,1,2'b00,0,0,0));
    tick();

    // jumps resolved in ID
    opcode = 6'b111010; next_state = ID; tick();
    next_state = IF; #1;
    check("jal_id", ctl, cw(0,1,2'b10,1,2'b10,2'b10,0,0));
    tick();
    opcode = 6'b111000; next_state = ID; tick();
    next_state = IF; #1;
    check("j_id", ctl, cw(0,1,2'b10,0,0,0,0,0));
    tick();
    opcode = 6'b111001; next_state = ID; tick();
    next_state = IF; #1;
    check("jr_id", ctl, cw(0,1,2'b11,0,0,0,0,0));
    tick();
    opcode = 6'b111100; next_state = ID; tick();
    next_state = IF; #1;
    check("nop_id", ctl, cw(0,1,2'b00,0,0,0,0,0));
    tick();
    check("jmp_cnt", instr_count, 10);

    // Reset during MEM of lw: no cWB
    opcode = 6'b110001; next_state = ID; tick();
    next_state = CEXE; tick();
    next_state = MEM; tick();
    next_state = CWB; #1;
    check("rmem_mem", ctl, cw(0,0,0,0,0,0,1,0));
    Reset = 1'b1; tick(); Reset = 1'b0; #1;
    check("rmem_state", state, IF);
    check("rmem_ctl", ctl, cw(1,0,0,0,0,0,0,0));
    check("rmem_cnt", instr_count, 0);

    // halt: retires in ID, freezes there
    opcode = 6'b111111; next_state = ID; tick();
    next_state = IF; #1;
    check("halt_id_ctl", ctl, cw(0,0,0,0,0,0,0,0));
    check("halt_id_flag", halted, 0);
    tick();
    check("halt_flag", halted, 1);
    check("halt_cnt", instr_count, 1);
    for (int i = 0; i < 10; i++) begin
      next_state = (i % 2 == 0) ? AWB : MEM;
      opcode = (i % 2 == 0) ? 6'b000000 : 6'b110000;
      #1;
      check("halt_state", state, ID);
      check("halt_ctl", ctl, 0);
      tick();
    end
    check("halt_cnt_hold", instr_count, 1);
    check("halt_hold", halted, 1);
    Reset = 1'b1; tick(); Reset = 1'b0; #1;
    check("unhalt_state", state, IF);
    check("unhalt_flag", halted, 0);
    check("unhalt_cnt", instr_count, 0);
    check("unhalt_ctl", ctl, cw(1,0,0,0,0,0,0,0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
